// File: rtl/sdlc_tx_framer.sv
// Econet SDLC transmit framer: opening flags, LSB-first data with zero insertion,
// CRC-16/X.25 FCS and closing flags, plus host- or underrun-triggered aborts.
module sdlc_tx_framer #(
  parameter int OPEN_FLAGS  = 1,
  parameter int CLOSE_FLAGS = 1,
  parameter int ABORT_ONES  = 8
) (
  input  logic       netclk,
  input  logic       reset,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  input  logic       tx_abort,
  output logic       txdata,
  output logic       txen,
  output logic       busy,
  output logic       tx_done,
  output logic       underrun
);
  typedef enum logic [2:0] {IDLE, OPEN, DATA, FCS, CLOSE, ABORT} state_t;

  localparam logic [7:0] FLAG       = 8'h7E;
  localparam logic [3:0] OPEN_LAST  = 4'(OPEN_FLAGS - 1);
  localparam logic [3:0] CLOSE_LAST = 4'(CLOSE_FLAGS - 1);
  localparam logic [3:0] ABORT_LAST = 4'(ABORT_ONES - 1);

  // state and counters describe the bit currently on txdata
  state_t      state, state_n;
  logic [3:0]  bit_cnt, bit_n, unit_cnt, unit_n, bit_inc;
  logic [2:0]  ones, ones_n;
  logic [15:0] sr, sr_n, crc, crc_n;
  logic        sh_last, last_n;
  logic [7:0]  hold;
  logic        hold_last, hold_full;
  logic        line_n, en_n, done_n, urun_n, take, cnt_ones, crc_upd;
  logic        accept, avail, abort_go, src_last;
  logic [7:0]  src_byte;

  assign busy     = (state != IDLE);
  assign tx_ready = ~hold_full & ~tx_abort & (state != ABORT);
  assign accept   = tx_valid & tx_ready;
  // a byte arriving on the boundary cycle is forwarded straight to the shifter
  assign avail    = hold_full | accept;
  assign src_byte = hold_full ? hold : tx_byte;
  assign src_last = hold_full ? hold_last : tx_last;
  assign bit_inc  = bit_cnt + 4'd1;
  assign abort_go = tx_abort & (state inside {OPEN, DATA, FCS, CLOSE});

  always_ff @(posedge netclk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      unit_cnt  <= '0;
      ones      <= '0;
      sr        <= '0;
      crc       <= 16'hFFFF;
      sh_last   <= 1'b0;
      hold      <= '0;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      txdata    <= 1'b1;
      txen      <= 1'b0;
      tx_done   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_n;
      unit_cnt <= unit_n;
      ones     <= ones_n;
      sr       <= sr_n;
      crc      <= crc_n;
      sh_last  <= last_n;
      txdata   <= line_n;
      txen     <= en_n;
      tx_done  <= done_n;
      underrun <= urun_n;
      if (state_n == ABORT || take) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold      <= tx_byte;
        hold_last <= tx_last;
        hold_full <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    bit_n    = bit_cnt;
    unit_n   = unit_cnt;
    ones_n   = ones;
    sr_n     = sr;
    crc_n    = crc;
    last_n   = sh_last;
    line_n   = 1'b1;
    en_n     = 1'b1;
    done_n   = 1'b0;
    urun_n   = 1'b0;
    take     = 1'b0;
    cnt_ones = 1'b0;
    crc_upd  = 1'b0;
    case (state)
      IDLE: begin
        en_n   = 1'b0;
        crc_n  = 16'hFFFF;
        ones_n = '0;
        if (accept) begin
          state_n = OPEN; bit_n = '0; unit_n = '0;
          line_n  = FLAG[0]; en_n = 1'b1;
          sr_n    = {8'h00, tx_byte}; last_n = tx_last; take = 1'b1;
        end
      end
      OPEN: begin
        ones_n = '0;
        if (bit_cnt != 4'd7) begin
          bit_n = bit_inc; line_n = FLAG[bit_inc[2:0]];
        end else if (unit_cnt != OPEN_LAST) begin
          unit_n = unit_cnt + 4'd1; bit_n = '0; line_n = FLAG[0];
        end else begin
          state_n = DATA; bit_n = '0;
          line_n  = sr[0]; sr_n = sr >> 1; cnt_ones = 1'b1; crc_upd = 1'b1;
        end
      end
      DATA: begin
        if (ones == 3'd5) begin
          line_n = 1'b0; ones_n = '0;
        end else if (bit_cnt != 4'd7) begin
          bit_n  = bit_inc;
          line_n = sr[0]; sr_n = sr >> 1; cnt_ones = 1'b1; crc_upd = 1'b1;
        end else if (sh_last) begin
          state_n = FCS; bit_n = '0;
          line_n  = ~crc[0]; sr_n = {1'b0, ~crc[15:1]}; cnt_ones = 1'b1;
        end else if (avail) begin
          bit_n  = '0;
          line_n = src_byte[0]; sr_n = {9'h000, src_byte[7:1]};
          last_n = src_last; take = 1'b1; cnt_ones = 1'b1; crc_upd = 1'b1;
        end else begin
          state_n = ABORT; bit_n = '0; urun_n = 1'b1;
        end
      end
      FCS: begin
        if (ones == 3'd5) begin
          line_n = 1'b0; ones_n = '0;
        end else if (bit_cnt != 4'd15) begin
          bit_n = bit_inc; line_n = sr[0]; sr_n = sr >> 1; cnt_ones = 1'b1;
        end else begin
          state_n = CLOSE; bit_n = '0; unit_n = '0; line_n = FLAG[0]; ones_n = '0;
        end
      end
      CLOSE: begin
        crc_n  = 16'hFFFF;
        ones_n = '0;
        if (bit_cnt != 4'd7) begin
          bit_n = bit_inc; line_n = FLAG[bit_inc[2:0]];
        end else if (unit_cnt != CLOSE_LAST) begin
          unit_n = unit_cnt + 4'd1; bit_n = '0; line_n = FLAG[0];
        end else begin
          done_n = 1'b1;
          if (avail) begin
            state_n = OPEN; bit_n = '0; unit_n = '0; line_n = FLAG[0];
            sr_n = {8'h00, src_byte}; last_n = src_last; take = 1'b1;
          end else begin
            state_n = IDLE; en_n = 1'b0;
          end
        end
      end
      ABORT: begin
        crc_n  = 16'hFFFF;
        ones_n = '0;
        if (bit_cnt != ABORT_LAST) bit_n = bit_inc;
        else begin
          state_n = IDLE; en_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    if (cnt_ones) ones_n = line_n ? ones + 3'd1 : 3'd0;
    if (crc_upd)  crc_n  = {1'b0, crc[15:1]} ^ ((crc[0] ^ line_n) ? 16'h8408 : 16'h0000);

    // host abort overrides everything, including a byte offered this cycle
    if (abort_go) begin
      state_n = ABORT; bit_n = '0; line_n = 1'b1; en_n = 1'b1;
      done_n  = 1'b0; urun_n = 1'b0; take = 1'b0;
      crc_n   = 16'hFFFF; ones_n = '0;
    end
  end
endmodule

// File: tb/tb_sdlc_tx_framer.sv
// Bench for sdlc_tx_framer: directed and random frames checked against a
// bit-stream model built from flags, stuffing rules and the X.25 FCS.
module tb_sdlc_tx_framer;
  localparam int OPEN_N  = 3;
  localparam int CLOSE_N = 1;
  localparam int ABORT_N = 8;

  logic       netclk   = 1'b0;
  logic       reset    = 1'b0;
  logic [7:0] tx_byte  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last  = 1'b0;
  logic       tx_abort = 1'b0;
  logic       tx_ready, txdata, txen, busy, tx_done, underrun;

  int checks = 0;
  int errors = 0;
  logic       got_q[$];
  logic       exp_q[$];
  logic [7:0] fq[$];
  int   n_done = 0, n_urun = 0, n_rise = 0;
  logic prev_en = 1'b0;
  int   g0, d0, u0, r0;

`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp); end end

  always #5 netclk = ~netclk;

  sdlc_tx_framer #(.OPEN_FLAGS(OPEN_N), .CLOSE_FLAGS(CLOSE_N), .ABORT_ONES(ABORT_N)) dut (
    .netclk(netclk), .reset(reset), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_last(tx_last), .tx_ready(tx_ready), .tx_abort(tx_abort), .txdata(txdata),
    .txen(txen), .busy(busy), .tx_done(tx_done), .underrun(underrun)
  );

  // line monitor: records every enabled bit and counts pulses
  always @(negedge netclk) begin
    if (txen) got_q.push_back(txdata);
    if (tx_done) n_done <= n_done + 1;
    if (underrun) n_urun <= n_urun + 1;
    if (txen && !prev_en) n_rise <= n_rise + 1;
    prev_en <= txen;
  end

  function automatic logic [15:0] crc_of();
    logic [15:0] c = 16'hFFFF;
    foreach (fq[k])
      for (int i = 0; i < 8; i++)
        c = (c >> 1) ^ ((c[0] ^ fq[k][i]) ? 16'h8408 : 16'h0000);
    return c;
  endfunction

  task automatic add_flags(input int n);
    for (int f = 0; f < n; f++)
      for (int i = 0; i < 8; i++) exp_q.push_back(i != 0 && i != 7);
  endtask

  task automatic add_stuffed(input logic [7:0] b, inout int run);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[i]);
      run = b[i] ? run + 1 : 0;
      if (run == 5) begin exp_q.push_back(1'b0); run = 0; end
    end
  endtask

  task automatic add_frame(input logic [15:0] fcs);
    int run = 0;
    add_flags(OPEN_N);
    foreach (fq[k]) add_stuffed(fq[k], run);
    add_stuffed(fcs[7:0], run);
    add_stuffed(fcs[15:8], run);
    add_flags(CLOSE_N);
  endtask

  task automatic mark();
    g0 = got_q.size(); d0 = n_done; u0 = n_urun; r0 = n_rise;
    exp_q.delete();
  endtask

  // presents one byte until accepted; call on a negative clock edge
  task automatic send_byte(input logic [7:0] b, input logic l);
    int n = 0;
    logic acc;
    tx_byte = b; tx_last = l; tx_valid = 1'b1;
    forever begin
      #1 acc = tx_ready;
      @(negedge netclk);
      if (acc) break;
      n++;
      if (n > 500) begin `CHK("accept timeout", acc, 1'b1) break; end
    end
    tx_valid = 1'b0; tx_last = 1'b0;
  endtask

  task automatic send_frame();
    foreach (fq[k]) send_byte(fq[k], k == fq.size() - 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin @(negedge netclk); n++; end while ((busy || txen) && n < 2000);
    `CHK($sformatf("%s idle", tag), busy | txen, 1'b0)
    @(negedge netclk);
  endtask

  task automatic check_stream(input string tag);
    int nbad = 0;
    int ngot = got_q.size() - g0;
    `CHK($sformatf("%s length", tag), ngot, exp_q.size())
    for (int i = 0; i < exp_q.size() && i < ngot; i++)
      if (got_q[g0 + i] !== exp_q[i]) nbad++;
    `CHK($sformatf("%s bits", tag), nbad, 0)
  endtask

  initial begin
    int bad, n, run;
    logic [8:0] v;

    // reset and quiet idle line
    repeat (3) @(negedge netclk);
    `CHK("rst txen", txen, 1'b0)
    `CHK("rst txdata", txdata, 1'b1)
    `CHK("rst tx_ready", tx_ready, 1'b1)
    `CHK("rst busy", busy, 1'b0)
    `CHK("rst tx_done", tx_done, 1'b0)
    `CHK("rst underrun", underrun, 1'b0)
    reset = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge netclk);
      if (txen !== 1'b0 || txdata !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) bad++;
    end
    `CHK("idle quiet", bad, 0)

    // "123456789": reference FCS 0x906E sent low byte first
    fq = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    mark(); add_frame(16'h906E);
    send_frame(); wait_idle("check");
    check_stream("check");
    `CHK("check tx_done", n_done - d0, 1)
    `CHK("check txen runs", n_rise - r0, 1)
    `CHK("check underrun", n_urun - u0, 0)

    // 0xFF: one stuffed zero after five ones
    fq = {8'hFF};
    mark(); add_frame(~crc_of());
    send_frame(); wait_idle("ff");
    check_stream("ff");
    v = '0;
    for (int i = 0; i < 9; i++) v = {v[7:0], got_q[g0 + OPEN_N * 8 + i]};
    `CHK("ff data bits", v, 9'h1F7)

    // underrun after 0x01 with no tx_last
    mark(); add_flags(OPEN_N);
    run = 0; add_stuffed(8'h01, run);
    repeat (ABORT_N) exp_q.push_back(1'b1);
    send_byte(8'h01, 1'b0); wait_idle("underrun");
    check_stream("underrun");
    `CHK("underrun pulses", n_urun - u0, 1)
    `CHK("underrun tx_done", n_done - d0, 0)

    // host abort on the 3rd data bit of 0x55, with 0x33 waiting in the holding register
    mark(); add_flags(OPEN_N);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    repeat (ABORT_N) exp_q.push_back(1'b1);
    send_byte(8'h55, 1'b0); send_byte(8'h33, 1'b0);
    n = 0;
    while (got_q.size() - g0 < OPEN_N * 8 + 3 && n < 500) begin @(negedge netclk); #1 n++; end
    tx_abort = 1'b1;
    @(negedge netclk);
    tx_abort = 1'b0;
    wait_idle("abort");
    check_stream("abort");
    `CHK("abort underrun", n_urun - u0, 0)
    `CHK("abort tx_done", n_done - d0, 0)

    // frame after abort: CRC restarts
    fq = {8'hA5, 8'h3C, 8'hFF};
    mark(); add_frame(~crc_of());
    send_frame(); wait_idle("post abort");
    check_stream("post abort");
    `CHK("post abort tx_done", n_done - d0, 1)

    // abort request in IDLE does nothing except hold off acceptance
    tx_abort = 1'b1; tx_valid = 1'b1; tx_byte = 8'hC3;
    #1 `CHK("idle abort ready", tx_ready, 1'b0)
    repeat (3) @(negedge netclk);
    `CHK("idle abort txen", txen, 1'b0)
    `CHK("idle abort busy", busy, 1'b0)
    tx_abort = 1'b0; tx_valid = 1'b0;

    // next frame presented during closing flag: no idle gap, two tx_done pulses
    fq = {8'hAA};
    mark(); add_frame(~crc_of());
    send_byte(8'hAA, 1'b1);
    n = 0;
    while (got_q.size() - g0 < exp_q.size() - 4 && n < 500) begin @(negedge netclk); #1 n++; end
    fq.delete();
    repeat (3) fq.push_back(8'($urandom));
    add_frame(~crc_of());
    send_frame(); wait_idle("b2b");
    check_stream("b2b");
    `CHK("b2b tx_done", n_done - d0, 2)
    `CHK("b2b txen runs", n_rise - r0, 1)

    // random frames with a bias toward runs of ones
    for (int f = 0; f < 4; f++) begin
      fq.delete();
      n = $urandom_range(1, 6);
      repeat (n) fq.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      mark(); add_frame(~crc_of());
      send_frame(); wait_idle("random");
      check_stream("random");
      `CHK("random tx_done", n_done - d0, 1)
    end

    // asynchronous reset mid-frame, no abort tail afterwards
    send_byte(8'hF0, 1'b0); send_byte(8'h0F, 1'b0);
    repeat (2) @(negedge netclk);
    #2 reset = 1'b0;
    #1;
    `CHK("async rst txen", txen, 1'b0)
    `CHK("async rst txdata", txdata, 1'b1)
    `CHK("async rst busy", busy, 1'b0)
    `CHK("async rst tx_ready", tx_ready, 1'b1)
    @(negedge netclk);
    reset = 1'b1;
    n = got_q.size();
    repeat (12) @(negedge netclk);
    `CHK("async rst silent", got_q.size() - n, 0)

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
